// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready flow control, optional 2-entry skid,
// synchronous flush, bubble-gated control bits and an EX-stage forwarding tap.
module ex_mem_stage #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 3,
    parameter int OP_W   = 4,
    parameter int IMM_W  = 3,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              write_mem_i,
    input  logic              write_reg_i,
    input  logic              read_mem_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] data_d_i,
    input  logic [REG_W-1:0]  reg1_i,
    input  logic [REG_W-1:0]  reg2_i,
    input  logic [REG_W-1:0]  reg_d_i,
    input  logic [OP_W-1:0]   opcode_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              write_mem_o,
    output logic              write_reg_o,
    output logic              read_mem_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [DATA_W-1:0] data_d_o,
    output logic [REG_W-1:0]  reg1_o,
    output logic [REG_W-1:0]  reg2_o,
    output logic [REG_W-1:0]  reg_d_o,
    output logic [OP_W-1:0]   opcode_o,
    output logic [IMM_W-1:0]  imm_o,
    output logic              fwd_valid_o,
    output logic [REG_W-1:0]  fwd_reg_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    localparam int PW = 3 + 4 * DATA_W + 3 * REG_W + OP_W + IMM_W;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_t;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] main_pay;
    logic          main_v;
    logic          write_mem;
    logic          write_reg;
    logic          read_mem;

    // The whole beat travels as one flat vector so both buffer variants copy it bit-exact.
    assign in_pay = {write_mem_i, write_reg_i, read_mem_i, data1_i, data2_i, alu_out_i,
                     data_d_i, reg1_i, reg2_i, reg_d_i, opcode_i, imm_i};

    assign {write_mem, write_reg, read_mem, data1_o, data2_o, alu_out_o,
            data_d_o, reg1_o, reg2_o, reg_d_o, opcode_o, imm_o} = main_pay;

    // Control bits are forced low on bubbles; data fields simply hold their last value.
    assign out_valid_o = main_v;
    assign write_mem_o = main_v & write_mem;
    assign write_reg_o = main_v & write_reg;
    assign read_mem_o  = main_v & read_mem;
    assign fwd_valid_o = main_v & write_reg & ~read_mem;
    assign fwd_reg_o   = reg_d_o;
    assign fwd_data_o  = alu_out_o;

    generate
        if (SKID != 0) begin : g_skid
            stage_t        state;
            logic [PW-1:0] skid_pay;
            logic          ready_q;

            // Main entry always drives the outputs; the skid entry only catches the beat
            // that arrives while MEM is stalled, keeping in_ready a pure register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state    <= EMPTY;
                    ready_q  <= 1'b1;
                    main_pay <= '0;
                    skid_pay <= '0;
                end else if (flush_i) begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_valid_i) begin
                                main_pay <= in_pay;
                                state    <= ONE;
                            end
                        end
                        ONE: begin
                            if (in_valid_i && out_ready_i) begin
                                main_pay <= in_pay;
                            end else if (in_valid_i) begin
                                skid_pay <= in_pay;
                                state    <= TWO;
                                ready_q  <= 1'b0;
                            end else if (out_ready_i) begin
                                state <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (out_ready_i) begin
                                main_pay <= skid_pay;
                                state    <= ONE;
                                ready_q  <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= EMPTY;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end

            assign main_v     = (state != EMPTY);
            assign in_ready_o = ready_q;
        end else begin : g_single
            logic valid_q;

            // Single entry: a new beat may replace the current one in the cycle it leaves.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q  <= 1'b0;
                    main_pay <= '0;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (in_valid_i && in_ready_o) begin
                    main_pay <= in_pay;
                    valid_q  <= 1'b1;
                end else if (out_ready_i) begin
                    valid_q <= 1'b0;
                end
            end

            assign main_v     = valid_q;
            assign in_ready_o = out_ready_i | ~valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage: a skid instance (8-bit) and a
// single-entry instance (16-bit) run side by side against queue-based reference models.
module tb_ex_mem_stage;

    typedef struct {
        logic        wm;
        logic        wr;
        logic        rm;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] alu;
        logic [15:0] dd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [2:0]  rd;
        logic [3:0]  op;
        logic [2:0]  imm;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        wm, wr, rm;
    logic [15:0] d1, d2, alu, dd;
    logic [2:0]  r1, r2, rd, imm;
    logic [3:0]  op;

    logic        s1_in_ready, s1_out_valid, s1_wm, s1_wr, s1_rm, s1_fwd_valid;
    logic [7:0]  s1_d1, s1_d2, s1_alu, s1_dd, s1_fwd_data;
    logic [2:0]  s1_r1, s1_r2, s1_rd, s1_imm, s1_fwd_reg;
    logic [3:0]  s1_op;

    logic        s0_in_ready, s0_out_valid, s0_wm, s0_wr, s0_rm, s0_fwd_valid;
    logic [15:0] s0_d1, s0_d2, s0_alu, s0_dd, s0_fwd_data;
    logic [2:0]  s0_r1, s0_r2, s0_rd, s0_imm, s0_fwd_reg;
    logic [3:0]  s0_op;

    int testCount = 0;
    int failCount = 0;

    beat_t q1[$];
    beat_t q0[$];

    ex_mem_stage #(.DATA_W(8), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(s1_in_ready),
        .write_mem_i(wm), .write_reg_i(wr), .read_mem_i(rm),
        .data1_i(d1[7:0]), .data2_i(d2[7:0]), .alu_out_i(alu[7:0]), .data_d_i(dd[7:0]),
        .reg1_i(r1), .reg2_i(r2), .reg_d_i(rd), .opcode_i(op), .imm_i(imm),
        .out_valid_o(s1_out_valid), .out_ready_i(out_ready),
        .write_mem_o(s1_wm), .write_reg_o(s1_wr), .read_mem_o(s1_rm),
        .data1_o(s1_d1), .data2_o(s1_d2), .alu_out_o(s1_alu), .data_d_o(s1_dd),
        .reg1_o(s1_r1), .reg2_o(s1_r2), .reg_d_o(s1_rd), .opcode_o(s1_op), .imm_o(s1_imm),
        .fwd_valid_o(s1_fwd_valid), .fwd_reg_o(s1_fwd_reg), .fwd_data_o(s1_fwd_data)
    );

    ex_mem_stage #(.DATA_W(16), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(s0_in_ready),
        .write_mem_i(wm), .write_reg_i(wr), .read_mem_i(rm),
        .data1_i(d1), .data2_i(d2), .alu_out_i(alu), .data_d_i(dd),
        .reg1_i(r1), .reg2_i(r2), .reg_d_i(rd), .opcode_i(op), .imm_i(imm),
        .out_valid_o(s0_out_valid), .out_ready_i(out_ready),
        .write_mem_o(s0_wm), .write_reg_o(s0_wr), .read_mem_o(s0_rm),
        .data1_o(s0_d1), .data2_o(s0_d2), .alu_out_o(s0_alu), .data_d_o(s0_dd),
        .reg1_o(s0_r1), .reg2_o(s0_r2), .reg_d_o(s0_rd), .opcode_o(s0_op), .imm_o(s0_imm),
        .fwd_valid_o(s0_fwd_valid), .fwd_reg_o(s0_fwd_reg), .fwd_data_o(s0_fwd_data)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic beat_t mkBeat(input logic [15:0] a, input logic w, input logic m,
                                     input logic [2:0] d);
        beat_t b;
        b.wm  = 1'($urandom);
        b.wr  = w;
        b.rm  = m;
        b.d1  = 16'($urandom);
        b.d2  = 16'($urandom);
        b.alu = a;
        b.dd  = 16'($urandom);
        b.r1  = 3'($urandom);
        b.r2  = 3'($urandom);
        b.rd  = d;
        b.op  = 4'($urandom);
        b.imm = 3'($urandom);
        return b;
    endfunction

    // Compare both instances against the heads of their model queues.
    task automatic checkAll();
        beat_t f;
        checkOutput("s1_out_valid", 32'(s1_out_valid), 32'(q1.size() > 0));
        checkOutput("s1_in_ready", 32'(s1_in_ready), 32'(q1.size() < 2));
        if (q1.size() > 0) begin
            f = q1[0];
            checkOutput("s1_alu", 32'(s1_alu), 32'(f.alu[7:0]));
            checkOutput("s1_data1", 32'(s1_d1), 32'(f.d1[7:0]));
            checkOutput("s1_data2", 32'(s1_d2), 32'(f.d2[7:0]));
            checkOutput("s1_data_d", 32'(s1_dd), 32'(f.dd[7:0]));
            checkOutput("s1_regs", 32'({s1_r1, s1_r2, s1_rd}), 32'({f.r1, f.r2, f.rd}));
            checkOutput("s1_op_imm", 32'({s1_op, s1_imm}), 32'({f.op, f.imm}));
            checkOutput("s1_ctrl", 32'({s1_wm, s1_wr, s1_rm}), 32'({f.wm, f.wr, f.rm}));
            checkOutput("s1_fwd_valid", 32'(s1_fwd_valid), 32'(f.wr & ~f.rm));
            checkOutput("s1_fwd_reg", 32'(s1_fwd_reg), 32'(f.rd));
            checkOutput("s1_fwd_data", 32'(s1_fwd_data), 32'(f.alu[7:0]));
        end else begin
            checkOutput("s1_bubble_ctrl", 32'({s1_wm, s1_wr, s1_rm, s1_fwd_valid}), 32'd0);
        end
        checkOutput("s0_out_valid", 32'(s0_out_valid), 32'(q0.size() > 0));
        checkOutput("s0_in_ready", 32'(s0_in_ready), 32'(out_ready | (q0.size() == 0)));
        if (q0.size() > 0) begin
            f = q0[0];
            checkOutput("s0_alu", 32'(s0_alu), 32'(f.alu));
            checkOutput("s0_data", 32'({s0_d1, s0_d2}), {f.d1, f.d2});
            checkOutput("s0_data_d", 32'(s0_dd), 32'(f.dd));
            checkOutput("s0_regs", 32'({s0_r1, s0_r2, s0_rd}), 32'({f.r1, f.r2, f.rd}));
            checkOutput("s0_op_imm", 32'({s0_op, s0_imm}), 32'({f.op, f.imm}));
            checkOutput("s0_ctrl", 32'({s0_wm, s0_wr, s0_rm}), 32'({f.wm, f.wr, f.rm}));
            checkOutput("s0_fwd", 32'({s0_fwd_valid, s0_fwd_reg}), 32'({f.wr & ~f.rm, f.rd}));
            checkOutput("s0_fwd_data", 32'(s0_fwd_data), 32'(f.alu));
        end else begin
            checkOutput("s0_bubble_ctrl", 32'({s0_wm, s0_wr, s0_rm, s0_fwd_valid}), 32'd0);
        end
    endtask

    // Drive one cycle from a negedge, advance both models at the posedge, check at the next negedge.
    task automatic applyStimulus(input logic v, input logic ordy, input logic fl, input beat_t b);
        logic rdy1, rdy0, pop1, pop0;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        wm = b.wm; wr = b.wr; rm = b.rm;
        d1 = b.d1; d2 = b.d2; alu = b.alu; dd = b.dd;
        r1 = b.r1; r2 = b.r2; rd = b.rd; op = b.op; imm = b.imm;
        #1;
        checkOutput("s0_in_ready_comb", 32'(s0_in_ready), 32'(ordy | (q0.size() == 0)));
        rdy1 = (q1.size() < 2);
        rdy0 = ordy | (q0.size() == 0);
        pop1 = (q1.size() > 0) && ordy;
        pop0 = (q0.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1) void'(q1.pop_front());
            if (pop0) void'(q0.pop_front());
            if (v && rdy1) q1.push_back(b);
            if (v && rdy0) q0.push_back(b);
        end
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        beat_t a1, a2, a3, nb;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        nb = mkBeat(16'h0, 1'b0, 1'b0, 3'd0);
        wm = 0; wr = 0; rm = 0; d1 = 0; d2 = 0; alu = 0; dd = 0;
        r1 = 0; r2 = 0; rd = 0; op = 0; imm = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAll();
        checkOutput("reset_alu_zero", 32'(s1_alu), 32'd0);
        checkOutput("reset_reg_d_zero", 32'(s1_rd), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, mkBeat(16'(8'h11 * (i + 1)), 1'b1, 1'b0, 3'(i)));
            checkOutput("stream_data", 32'(s1_alu), 32'(8'h11 * (i + 1)));
            checkOutput("stream_ready", 32'(s1_in_ready), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, nb);

        a1 = mkBeat(16'hA1, 1'b1, 1'b0, 3'd1);
        a2 = mkBeat(16'hA2, 1'b1, 1'b0, 3'd2);
        a3 = mkBeat(16'hA3, 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, a1);
        applyStimulus(1'b1, 1'b0, 1'b0, a2);
        checkOutput("bp_head_a1", 32'(s1_alu), 32'hA1);
        checkOutput("bp_ready_low", 32'(s1_in_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, a3);
        checkOutput("bp_stall_a1", 32'(s1_alu), 32'hA1);
        applyStimulus(1'b1, 1'b1, 1'b0, a3);
        checkOutput("bp_order_a2", 32'(s1_alu), 32'hA2);
        applyStimulus(1'b1, 1'b1, 1'b0, a3);
        checkOutput("bp_order_a3", 32'(s1_alu), 32'hA3);
        applyStimulus(1'b0, 1'b1, 1'b0, nb);
        checkOutput("bp_drained", 32'(s1_out_valid), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, a1);
        applyStimulus(1'b1, 1'b0, 1'b0, a2);
        applyStimulus(1'b1, 1'b0, 1'b1, a3);
        checkOutput("flush_valid", 32'(s1_out_valid), 32'd0);
        checkOutput("flush_write_mem", 32'(s1_wm), 32'd0);
        checkOutput("flush_ready", 32'(s1_in_ready), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, nb);
        checkOutput("flush_no_a3", 32'(s1_out_valid), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, mkBeat(16'h7E, 1'b1, 1'b0, 3'd5));
        checkOutput("fwd_valid", 32'(s1_fwd_valid), 32'd1);
        checkOutput("fwd_reg", 32'(s1_fwd_reg), 32'd5);
        checkOutput("fwd_data", 32'(s1_fwd_data), 32'h7E);
        applyStimulus(1'b1, 1'b1, 1'b0, mkBeat(16'h7E, 1'b1, 1'b1, 3'd5));
        checkOutput("fwd_load_blocked", 32'(s1_fwd_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, nb);

        applyStimulus(1'b1, 1'b0, 1'b0, mkBeat(16'hBEEF, 1'b0, 1'b0, 3'd0));
        checkOutput("s0_beef", 32'(s0_alu), 32'hBEEF);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'(i % 2), 1'b0, nb);

        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                in_valid = 1'b1;
                rst = 1'b1;
                #1;
                checkOutput("midrst_s1_valid", 32'(s1_out_valid), 32'd0);
                checkOutput("midrst_s1_write_reg", 32'(s1_wr), 32'd0);
                checkOutput("midrst_s1_ready", 32'(s1_in_ready), 32'd1);
                checkOutput("midrst_s1_alu", 32'(s1_alu), 32'd0);
                checkOutput("midrst_s0_valid", 32'(s0_out_valid), 32'd0);
                checkOutput("midrst_s0_alu", 32'(s0_alu), 32'd0);
                q1.delete();
                q0.delete();
                @(posedge clk);
                @(negedge clk);
                checkAll();
                rst = 1'b0;
            end
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 15) == 0),
                          mkBeat(16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
